// File: rtl/rand_arbiter_pkg.sv
// rtl/rand_arbiter_pkg.sv - shared constants, state encoding and LFSR step function
// Purpose: common definitions for the random-source arbiter.
//   LFSR_RESET_SEED : value forced after reset, after a zero seed, and on lock-up
//   LFSR_TAP_MASK   : feedback taps (bits 7,5,4,3)
//   arb_state_e     : IDLE / STEP / GRANT, 2-bit encoding
//   lfsr_next()     : one Fibonacci shift without zero substitution
package rand_arbiter_pkg;

  localparam logic [7:0] LFSR_RESET_SEED = 8'h0F;
  localparam logic [7:0] LFSR_TAP_MASK   = 8'hB8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP  = 2'd1,
    ST_GRANT = 2'd2
  } arb_state_e;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAP_MASK)};
  endfunction

endpackage

// File: rtl/rand_arbiter_if.sv
// rtl/rand_arbiter_if.sv - request/grant bus between game logic and the arbiter
// Purpose: groups the requester handshake, seeding and status signals.
//   req       : level request per requester, held until its ack
//   ack       : one-hot single-cycle grant, rand_out valid alongside it
//   rand_out  : delivered random value, held until the next grant
//   seed_load : load seed (honoured only while not busy)
//   seed      : seed value
//   busy      : arbiter is stepping or granting
// master = game-logic side, slave = arbiter side.
interface rand_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic [7:0]         rand_out;
  logic               seed_load;
  logic [7:0]         seed;
  logic               busy;

  modport master (
    output req, seed_load, seed,
    input  ack, rand_out, busy
  );

  modport slave (
    input  req, seed_load, seed,
    output ack, rand_out, busy
  );
endinterface

// File: rtl/rand_lfsr8.sv
// rtl/rand_lfsr8.sv - 8-bit Fibonacci LFSR with seeding and lock-up recovery
// Purpose: the shared random source.
//   clk, reset  : clock, asynchronous active-low reset (resets to LFSR_RESET_SEED)
//   step        : advance one position this edge
//   load        : load load_value this edge (a zero value loads LFSR_RESET_SEED)
//   load_value  : seed to load
//   next_value  : value the register takes if it advances on this edge
module rand_lfsr8
  import rand_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic [7:0] next_value
);

  logic [7:0] value_q;

  // A zero register can never shift out of zero, so recovery replaces the shift.
  always_comb begin
    next_value = lfsr_next(value_q);
    if (value_q == 8'h00) begin
      next_value = LFSR_RESET_SEED;
    end
  end

  // Load wins over stepping; zero recovery happens even when not stepping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= LFSR_RESET_SEED;
    end else if (load) begin
      value_q <= (load_value == 8'h00) ? LFSR_RESET_SEED : load_value;
    end else if (value_q == 8'h00) begin
      value_q <= LFSR_RESET_SEED;
    end else if (step) begin
      value_q <= next_value;
    end
  end

endmodule

// File: rtl/rand_arbiter.sv
// rtl/rand_arbiter.sv - round-robin arbiter sharing one LFSR among requesters
// Purpose: grants requesters in round-robin order; each grant delivers an LFSR
// value at least MIN_STEPS shifts after the request was sampled.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : rand_arbiter_if slave (req/seed_load/seed in, ack/rand_out/busy out)
// Parameters: NUM_REQ (2..8), MIN_STEPS (1..15), FREE_RUN (1 = LFSR also runs in IDLE).
// The interface instance must be built with the same NUM_REQ.
module rand_arbiter
  import rand_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MIN_STEPS = 3,
  parameter int FREE_RUN  = 1
) (
  input  logic           clk,
  input  logic           reset,
  rand_arbiter_if.slave  bus
);

  localparam logic [3:0] NREQ     = 4'(NUM_REQ);
  localparam logic [2:0] LAST_IDX = 3'(NUM_REQ - 1);
  localparam logic [3:0] STEPS    = 4'(MIN_STEPS);

  arb_state_e         state_q;
  logic [2:0]         ptr_q;
  logic [2:0]         winner_q;
  logic [3:0]         cnt_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [7:0]         rand_q;

  logic [7:0] req_ext;
  logic [3:0] cand;
  logic [2:0] pick_d;
  logic [7:0] win_onehot;
  logic       lfsr_step;
  logic       lfsr_load;
  logic [7:0] lfsr_next_value;

  // Scan offsets from far to near so the nearest set bit at or after ptr wins.
  always_comb begin
    req_ext = 8'(bus.req);
    cand    = 4'd0;
    pick_d  = ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_q} + 4'(i);
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (req_ext[cand[2:0]]) begin
        pick_d = cand[2:0];
      end
    end
  end

  assign win_onehot = 8'h01 << winner_q;
  assign lfsr_step  = (state_q == ST_STEP) || ((state_q == ST_IDLE) && (FREE_RUN != 0));
  assign lfsr_load  = (state_q == ST_IDLE) && bus.seed_load;

  rand_lfsr8 u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .step       (lfsr_step),
    .load       (lfsr_load),
    .load_value (bus.seed),
    .next_value (lfsr_next_value)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 3'd0;
      winner_q <= 3'd0;
      cnt_q    <= 4'd0;
      ack_q    <= '0;
      rand_q   <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A seeding cycle never samples requests.
          if ((|bus.req) && !bus.seed_load) begin
            winner_q <= pick_d;
            cnt_q    <= STEPS;
            state_q  <= ST_STEP;
          end
        end
        ST_STEP: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= ST_GRANT;
            rand_q  <= lfsr_next_value;
            // A requester that withdrew gets no ack, but the value is still consumed.
            ack_q   <= win_onehot[NUM_REQ-1:0] & bus.req;
          end
        end
        ST_GRANT: begin
          ack_q   <= '0;
          ptr_q   <= (winner_q == LAST_IDX) ? 3'd0 : winner_q + 3'd1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ack      = ack_q;
  assign bus.rand_out = rand_q;
  assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rand_arbiter.sv
// tb/tb_rand_arbiter.sv - scoreboard bench for rand_arbiter (NUM_REQ=4, MIN_STEPS=2, FREE_RUN=0)
module tb_rand_arbiter;

  localparam int NR = 4;
  localparam int MS = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;

  rand_arbiter_if #(.NUM_REQ(NR)) bus ();

  rand_arbiter #(.NUM_REQ(NR), .MIN_STEPS(MS), .FREE_RUN(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] val;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] m_lfsr = 8'h0F;
  int         m_ptr = 0;
  logic [7:0] held = 8'h00;
  bit         hold_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sequence position model: every value is the seed pushed forward n shifts.
  function automatic logic [7:0] ref_adv(input logic [7:0] v, input int n);
    logic [7:0] x;
    x = v;
    for (int k = 0; k < n; k++) begin
      x = (x == 8'h00) ? 8'h0F : {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    end
    return x;
  endfunction

  // Monitor: pops the scoreboard on every ack and checks hold/spacing.
  initial begin
    int   cyc;
    int   last;
    exp_t e;
    logic [3:0] e_ack;
    cyc  = 0;
    last = -100;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        last = -100;
      end else if (bus.ack != '0) begin
        chk("ack_onehot", 32'($onehot(bus.ack)), 32'd1);
        chk("ack_spacing", 32'((cyc - last) >= MS + 2), 32'd1);
        last = cyc;
        if (sb.size() == 0) begin
          chk("ack_unexpected", 32'(bus.ack), 32'd0);
        end else begin
          e     = sb.pop_front();
          e_ack = 4'b0001 << e.idx;
          chk("ack_index", 32'(bus.ack), 32'(e_ack));
          chk("rand_out", 32'(bus.rand_out), 32'(e.val));
          held = e.val;
        end
      end else if (hold_en) begin
        chk("rand_hold", 32'(bus.rand_out), 32'(held));
      end
    end
  end

  task automatic seed_in(input logic [7:0] s);
    bus.seed      = s;
    bus.seed_load = 1'b1;
    @(posedge clk); #1;
    bus.seed_load = 1'b0;
    m_lfsr = (s == 8'h00) ? 8'h0F : s;
  endtask

  // Issue one round: expected grants are pushed before the reqs go up.
  task automatic run_round(input logic [3:0] mask, input bit busy_pulses, output int lat);
    int n;
    int last_i;
    int budget;
    budget = NR * (MS + 3) + 20;
    last_i = m_ptr;
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (m_ptr + k) % NR;
      if (mask[i]) begin
        m_lfsr = ref_adv(m_lfsr, MS);
        sb.push_back('{idx: i, val: m_lfsr});
        last_i = i;
      end
    end
    m_ptr = (last_i + 1) % NR;
    bus.req = mask;
    n   = 0;
    lat = -1;
    while (bus.req != '0 && n < budget) begin
      @(posedge clk); #1;
      n++;
      bus.seed_load = 1'b0;
      if (bus.ack != '0) begin
        if (lat < 0) lat = n;
        bus.req = bus.req & ~bus.ack;
      end
      if (busy_pulses && bus.busy && $urandom_range(0, 2) == 0) begin
        bus.seed      = 8'($urandom);
        bus.seed_load = 1'b1;
      end
    end
    if (bus.req != '0) begin
      chk("round_timeout", 32'(bus.req), 32'd0);
      bus.req = '0;
    end
    @(posedge clk); #1;
    bus.seed_load = 1'b0;
    @(posedge clk); #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    int lat;
    bus.req       = '0;
    bus.seed_load = 1'b0;
    bus.seed      = 8'h00;
    reset         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rand", 32'(bus.rand_out), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Post-reset sequence 3E, FB on requester 0, plus latency.
    run_round(4'b0001, 1'b0, lat);
    chk("latency", 32'(lat), 32'(MS + 1));
    run_round(4'b0001, 1'b0, lat);

    // Zero seed restarts at 0F; seed 01 yields 04 then 11.
    seed_in(8'h00);
    run_round(4'b0010, 1'b0, lat);
    seed_in(8'h01);
    run_round(4'b0100, 1'b0, lat);
    run_round(4'b1000, 1'b0, lat);

    // All requesters: 0,1,2,3 then 0 again.
    run_round(4'b1111, 1'b0, lat);
    run_round(4'b0001, 1'b0, lat);

    // Requester 2 withdraws during STEP: no ack, value consumed, ptr -> 3.
    hold_en = 1'b0;
    bus.req = 4'b0100;
    @(posedge clk); #1;
    bus.req = 4'b0000;
    repeat (5) @(posedge clk);
    #1;
    m_lfsr = ref_adv(m_lfsr, MS);
    m_ptr  = 3;
    chk("suppr_rand", 32'(bus.rand_out), 32'(m_lfsr));
    chk("suppr_busy", 32'(bus.busy), 32'd0);
    held    = m_lfsr;
    hold_en = 1'b1;
    run_round(4'b0101, 1'b0, lat);

    // seed_load while busy must not disturb the sequence.
    for (int r = 0; r < 6; r++) begin
      run_round(4'($urandom_range(1, 15)), 1'b1, lat);
    end

    // Reset in the middle of STEP.
    bus.req = 4'b0010;
    @(posedge clk); #1;
    chk("midrst_busy_before", 32'(bus.busy), 32'd1);
    hold_en = 1'b0;
    reset   = 1'b0;
    #1;
    chk("midrst_ack", 32'(bus.ack), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_rand", 32'(bus.rand_out), 32'd0);
    bus.req = '0;
    @(posedge clk); #1;
    reset   = 1'b1;
    m_lfsr  = 8'h0F;
    m_ptr   = 0;
    held    = 8'h00;
    hold_en = 1'b1;
    @(posedge clk); #1;
    run_round(4'b0010, 1'b0, lat);

    // Randomized rounds with occasional seeding and busy-time seed pulses.
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        seed_in(8'($urandom_range(0, 255)));
      end
      run_round(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
